// File: rtl/ser_byte_tx_pkg.sv
// Shared types for the serial byte transmitter feeding the sequence detector.
package seq_det_pkg;

    localparam int BITS_PER_BYTE = 8;

    typedef logic [BITS_PER_BYTE-1:0] byte_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } tx_state_e;

endpackage

// File: rtl/ser_byte_tx_if.sv
// Byte-input handshake and serial-output bundle of ser_byte_tx.
interface ser_byte_tx_if #(
    parameter int DEPTH = 4
);
    import seq_det_pkg::*;

    localparam int LVL_W = $clog2(DEPTH) + 1;

    byte_t            in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_data;
    logic             tx_active;
    logic             byte_done;
    logic [LVL_W-1:0] fifo_level;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  ser_data,
        input  tx_active,
        input  byte_done,
        input  fifo_level
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output ser_data,
        output tx_active,
        output byte_done,
        output fifo_level
    );

endinterface

// File: rtl/ser_tx_fifo.sv
// Show-ahead synchronous byte FIFO; pointers carry one extra wrap bit.
module ser_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  seq_det_pkg::byte_t       wdata_i,
    output seq_det_pkg::byte_t       rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    import seq_det_pkg::*;

    localparam int AW = $clog2(DEPTH);

    byte_t       mem_q [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic [AW:0] level_q;
    logic        push_ok;
    logic        pop_ok;

    // Same address with differing wrap bits means the write side lapped the read side.
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign level_o = level_q;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/ser_byte_tx.sv
// Byte-to-serial transmitter: FIFO-buffered bytes shifted out LSB-first, one bit per clock.
module ser_byte_tx #(
    parameter int DEPTH = 4,
    parameter int GAP   = 0
) (
    input  logic          clk,
    input  logic          rst,
    ser_byte_tx_if.slave  bus
);
    import seq_det_pkg::*;

    localparam int              CNT_W    = $clog2(BITS_PER_BYTE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BITS_PER_BYTE - 1);
    localparam logic [7:0]      GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    localparam logic [1:0] S_IDLE  = seq_det_pkg::IDLE;
    localparam logic [1:0] S_SHIFT = seq_det_pkg::SHIFT;
    localparam logic [1:0] S_GAP   = seq_det_pkg::GAP;

    logic [1:0]       state_q,   state_d;
    byte_t            shift_q,   shift_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]       gap_cnt_q, gap_cnt_d;
    logic             ser_q,     ser_d;
    logic             active_q,  active_d;
    logic             done_q,    done_d;

    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    byte_t            fifo_rdata;
    logic [$clog2(DEPTH):0] fifo_level;

    ser_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.in_valid && bus.in_ready),
        .pop_i   (fifo_pop),
        .wdata_i (bus.in_data),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign bus.in_ready   = !fifo_full && !rst;
    assign bus.ser_data   = ser_q;
    assign bus.tx_active  = active_q;
    assign bus.byte_done  = done_q;
    assign bus.fifo_level = fifo_level;

    // Outputs are registered, so each bit appears the cycle after the SHIFT edge that consumes it.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        fifo_pop  = 1'b0;
        ser_d     = 1'b0;
        active_d  = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_rdata;
                    bit_cnt_d = '0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                ser_d     = shift_q[0];
                active_d  = 1'b1;
                shift_d   = shift_q >> 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == CNT_LAST) begin
                    done_d = 1'b1;
                    if (GAP > 0) begin
                        gap_cnt_d = '0;
                        state_d   = S_GAP;
                    end else if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        shift_d   = fifo_rdata;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q + 8'd1;
                if (gap_cnt_q == GAP_LAST) begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        shift_d   = fifo_rdata;
                        bit_cnt_d = '0;
                        state_d   = S_SHIFT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            ser_q     <= 1'b0;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            ser_q     <= ser_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_ser_byte_tx.sv
// Drives GAP=0 and GAP=2 transmitters with shared stimulus; each checked against a byte-schedule model.
module tb_ser_byte_tx;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       tb_rst;
    logic       tb_valid;
    logic [7:0] tb_data;

    int n_checks = 0;
    int n_fail   = 0;
    int t        = 0;

    ser_byte_tx_if #(.DEPTH(DEPTH)) if0 ();
    ser_byte_tx_if #(.DEPTH(DEPTH)) if2 ();

    assign if0.in_valid = tb_valid;
    assign if0.in_data  = tb_data;
    assign if2.in_valid = tb_valid;
    assign if2.in_data  = tb_data;

    ser_byte_tx #(.DEPTH(DEPTH), .GAP(0)) dut0 (.clk(clk), .rst(tb_rst), .bus(if0));
    ser_byte_tx #(.DEPTH(DEPTH), .GAP(2)) dut2 (.clk(clk), .rst(tb_rst), .bus(if2));

    always #5 clk = ~clk;

    // Model: per accepted byte, the edge it was accepted and the edge it is loaded into the shifter.
    int         acc_t [2][256];
    int         ld_t  [2][256];
    logic [7:0] mb    [2][256];
    int         n_acc [2];

    logic        rdy_seen [2];
    logic [31:0] lvl_seen [2];
    logic        acc_now  [2];
    logic [15:0] cap      [2];
    int          act_cnt  [2];
    int          done_cnt [2];
    int          last_done[2];
    int          prev_done[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    function automatic int gap_of(input int k);
        return (k == 0) ? 0 : 2;
    endfunction

    function automatic int lvl_m(input int k, input int now);
        int n = 0;
        for (int i = 0; i < n_acc[k]; i++) begin
            if (acc_t[k][i] <= now) n++;
            if (ld_t[k][i] <= now) n--;
        end
        return n;
    endfunction

    // A byte is loaded the edge after acceptance, or when the previous byte (plus gap) frees the shifter.
    task automatic model_push(input int k, input logic [7:0] d, input int edge_t);
        int i = n_acc[k];
        int rdy_edge;
        rdy_edge = (i > 0) ? ld_t[k][i-1] + 8 + gap_of(k) : -1000;
        acc_t[k][i] = edge_t;
        ld_t[k][i]  = (edge_t < rdy_edge) ? rdy_edge : edge_t + 1;
        mb[k][i]    = d;
        n_acc[k]    = i + 1;
        $display("dut%0d accept byte=%02h edge=%0d load_edge=%0d", gap_of(k), d, edge_t, ld_t[k][i]);
    endtask

    task automatic cycle(input logic v, input logic [7:0] d, input logic r);
        logic e_ser, e_act, e_done;
        logic o_ser, o_act, o_done;
        logic [31:0] o_lvl;
        int dt;
        tb_valid = v;
        tb_data  = d;
        tb_rst   = r;
        #1;
        for (int k = 0; k < 2; k++) begin
            rdy_seen[k] = (k == 0) ? if0.in_ready : if2.in_ready;
            lvl_seen[k] = (k == 0) ? 32'(if0.fifo_level) : 32'(if2.fifo_level);
            acc_now[k]  = v && !r && (lvl_m(k, t) < DEPTH);
            check($sformatf("in_ready_g%0d", gap_of(k)), 32'(rdy_seen[k]), 32'(!r && (lvl_m(k, t) < DEPTH)));
        end
        @(posedge clk);
        t++;
        for (int k = 0; k < 2; k++) begin
            if (r) n_acc[k] = 0;
            else if (acc_now[k]) model_push(k, d, t);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            e_ser = 1'b0; e_act = 1'b0; e_done = 1'b0;
            for (int i = 0; i < n_acc[k]; i++) begin
                dt = t - ld_t[k][i];
                if (dt >= 1 && dt <= 8) begin
                    e_ser  = mb[k][i][dt-1];
                    e_act  = 1'b1;
                    e_done = (dt == 8);
                end
            end
            o_ser  = (k == 0) ? if0.ser_data  : if2.ser_data;
            o_act  = (k == 0) ? if0.tx_active : if2.tx_active;
            o_done = (k == 0) ? if0.byte_done : if2.byte_done;
            o_lvl  = (k == 0) ? 32'(if0.fifo_level) : 32'(if2.fifo_level);
            check($sformatf("ser_data_g%0d", gap_of(k)),   32'(o_ser),  32'(e_ser));
            check($sformatf("tx_active_g%0d", gap_of(k)),  32'(o_act),  32'(e_act));
            check($sformatf("byte_done_g%0d", gap_of(k)),  32'(o_done), 32'(e_done));
            check($sformatf("fifo_level_g%0d", gap_of(k)), o_lvl, 32'(lvl_m(k, t)));
            if (o_act === 1'b1) begin
                cap[k] = {o_ser, cap[k][15:1]};
                act_cnt[k]++;
            end
            if (o_done === 1'b1) begin
                done_cnt[k]++;
                prev_done[k] = last_done[k];
                last_done[k] = t;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 8'($urandom), 1'b0);
    endtask

    task automatic clr_stats();
        for (int k = 0; k < 2; k++) begin
            act_cnt[k]  = 0;
            done_cnt[k] = 0;
            cap[k]      = '0;
        end
    endtask

    initial begin
        int bp_cnt [2];
        logic bp_fell [2];
        for (int k = 0; k < 2; k++) begin
            n_acc[k] = 0; last_done[k] = 0; prev_done[k] = 0;
        end
        clr_stats();

        repeat (3) cycle(1'b0, 8'h00, 1'b1);
        idle(2);

        // Single byte.
        clr_stats();
        cycle(1'b1, 8'hA5, 1'b0);
        idle(14);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("a5_bits_g%0d", gap_of(k)), 32'(cap[k][15:8]), 32'hA5);
            check($sformatf("a5_done_g%0d", gap_of(k)), 32'(done_cnt[k]), 32'd1);
        end

        // Back-to-back pair.
        clr_stats();
        cycle(1'b1, 8'h0F, 1'b0);
        cycle(1'b1, 8'hF0, 1'b0);
        idle(24);
        check("pair_bits_g0", 32'(cap[0]), 32'hF00F);
        check("pair_active_g0", 32'(act_cnt[0]), 32'd16);
        check("pair_spacing_g0", 32'(last_done[0] - prev_done[0]), 32'd8);

        // Two 0xFF bytes: gap shows up as spacing between done pulses.
        clr_stats();
        cycle(1'b1, 8'hFF, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0);
        idle(26);
        check("ff_spacing_g0", 32'(last_done[0] - prev_done[0]), 32'd8);
        check("ff_spacing_g2", 32'(last_done[1] - prev_done[1]), 32'd10);

        // Backpressure from idle with in_valid held high.
        for (int k = 0; k < 2; k++) begin bp_cnt[k] = 0; bp_fell[k] = 1'b0; end
        for (int j = 0; j < 24; j++) begin
            cycle(1'b1, 8'(8'h10 + j), 1'b0);
            for (int k = 0; k < 2; k++) begin
                if (!bp_fell[k]) begin
                    if (rdy_seen[k] === 1'b1) bp_cnt[k]++;
                    else begin
                        bp_fell[k] = 1'b1;
                        check($sformatf("bp_level_g%0d", gap_of(k)), lvl_seen[k], 32'd4);
                    end
                end
            end
        end
        for (int k = 0; k < 2; k++)
            check($sformatf("bp_accepts_g%0d", gap_of(k)), 32'(bp_cnt[k]), 32'd5);
        idle(100);

        // Reset mid-byte with two bytes queued, then a clean byte.
        clr_stats();
        cycle(1'b1, 8'h3C, 1'b0);
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        idle(2);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        idle(12);
        for (int k = 0; k < 2; k++)
            check($sformatf("rst_no_done_g%0d", gap_of(k)), 32'(done_cnt[k]), 32'd0);
        clr_stats();
        cycle(1'b1, 8'h81, 1'b0);
        idle(14);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("post_rst_bits_g%0d", gap_of(k)), 32'(cap[k][15:8]), 32'h81);
            check($sformatf("post_rst_done_g%0d", gap_of(k)), 32'(done_cnt[k]), 32'd1);
        end

        // Random traffic with occasional resets.
        for (int j = 0; j < 800; j++) begin
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'((j % 150) == 149 || $urandom_range(0, 199) == 0));
        end
        idle(60);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
